hazard_ctl: RTL and testbench
=============================

Name: hazard_ctl

Overview:
Pipeline hazard controller for the 4-stage MIPS core (IF, ID, EX, ME, where ME writes back). It drives the pipeline-wide AnyStall line.
- Detects load-use and HI/LO-busy hazards and stalls IF/ID.
- Inserts bubbles into EX and flushes wrong-path instructions on jump or taken branch.
- Generates ME->EX forwarding selects.
- Sequences the multicycle mult/div unit with a busy counter FSM and keeps a saturating stall-cycle counter for performance debug.

Parameters:
MD_LATENCY, 8, cycles the mult/div unit occupies after issue (min 2, max 31)
CNT_W, 16, width of stall-cycle counter

Ports:
clk  in  1  core clock
reset  in  1  synchronous active-high reset
Rs_ID  in  5  source register A of instruction in ID
Rt_ID  in  5  source register B of instruction in ID
UsesHiLo_ID  in  1  ID instruction reads HI/LO (mfhi/mflo) or issues mult/div
Rs_EX  in  5  source A of instruction in EX
Rt_EX  in  5  source B of instruction in EX
WriteReg_EX  in  5  destination of EX instruction
RegWrite_EX  in  1  EX instruction writes a register
MemToReg_EX  in  1  EX instruction is a load
MdStart_EX  in  1  mult/div issuing from EX this cycle
WriteReg_ME  in  5  destination of ME instruction
RegWrite_ME  in  1  ME instruction writes a register
Jump_ID  in  1  jump resolved in ID
BranchTaken_EX  in  1  branch resolved taken in EX
FwdA_EX  out  1  select ME result for EX operand A
FwdB_EX  out  1  select ME result for EX operand B
AnyStall  out  1  hold PC and IF/ID register
Flush_ID  out  1  clear IF/ID register at next edge
Flush_EX  out  1  clear ID/EX register at next edge (bubble)
MdBusy  out  1  mult/div unit occupied
StallCnt  out  CNT_W  saturating count of stall cycles

Behaviour:
- Clock and reset: single clock; all state updates on posedge clk.
- Reset behaviour: while reset=1, every output is 0 (combinational outputs gated by reset). The FSM returns to RUN, the mult/div counter clears and StallCnt clears on the next edge. Reset mid-mult/div abandons the operation; MdBusy=0 the cycle after reset deasserts.
- Register 0: a destination of 5'd0 never matches for forwarding or for load-use detection.
- Forwarding (combinational, zero latency): FwdA_EX = RegWrite_ME & WriteReg_ME!=0 & WriteReg_ME==Rs_EX. FwdB_EX is the same using Rt_EX. Forwarding is independent of stall and flush.
- Load-use: LdUse = RegWrite_EX & MemToReg_EX & WriteReg_EX!=0 & (WriteReg_EX==Rs_ID | WriteReg_EX==Rt_ID). LdUse gives AnyStall=1 and Flush_EX=1 for exactly one cycle, since the bubble removes the condition next cycle.
- Mult/div FSM:
  - States RUN and MD_WAIT, with a 5-bit down-counter MdCnt.
  - RUN: when MdStart_EX=1, go to MD_WAIT and load MdCnt=MD_LATENCY-1.
  - MD_WAIT: MdBusy=1 and MdCnt decrements each cycle. At MdCnt==0, return to RUN.
  - MdBusy is therefore high for exactly MD_LATENCY cycles starting the cycle after issue.
  - MdStart_EX while in MD_WAIT is ignored; it cannot occur legally because of the HiLo stall.
- HI/LO stall: MdStall = MdBusy & UsesHiLo_ID gives AnyStall=1 and Flush_EX=1. It releases the same cycle MdBusy falls.
- Control flow:
  - BranchTaken_EX gives Flush_ID=1 and Flush_EX=1, and overrides AnyStall to 0 so the redirect PC loads.
  - Jump_ID, when there is no branch and no stall, gives Flush_ID=1 only.
  - Jump_ID during AnyStall gives no flush; the jump re-evaluates next cycle.
- Priority: reset > BranchTaken_EX > LdUse > MdStall > Jump_ID.
- Simultaneous conditions: LdUse and MdStall together give one stall cycle per cycle, with no double counting.
- StallCnt: increments by 1 on each cycle AnyStall=1. It saturates at all-ones and does not wrap.

Decomposition:
- Shared package: FSM state encoding (RUN=1'b0, MD_WAIT=1'b1), REG_ZERO=5'd0, and the forwarding-select constants.
- One natural sub-module, hazard_fwd: pure combinational forwarding compare, instantiated once with both operands.
- The FSM, counters and stall/flush logic stay in hazard_ctl.

Test Plan:
- Load-use: lw to $t0 in EX, add in ID reading $t0 -> AnyStall=1 and Flush_EX=1 for 1 cycle, then 0; StallCnt=1.
- Forwarding: RegWrite_ME=1, WriteReg_ME=5, Rs_EX=5, Rt_EX=5 -> FwdA_EX=FwdB_EX=1. Repeat with WriteReg_ME=0 -> both 0.
- Mult/div: MdStart_EX pulse, then mflo held in ID -> MdBusy high 8 cycles, AnyStall high 8 cycles, released the cycle MdBusy falls; StallCnt=8.
- Branch priority: BranchTaken_EX=1 together with LdUse true -> Flush_ID=1, Flush_EX=1, AnyStall=0.
- Jump during stall: Jump_ID=1 with LdUse -> Flush_ID=0 that cycle; next cycle with no stall -> Flush_ID=1.
- Reset mid-op: assert reset 3 cycles into MD_WAIT -> all outputs 0 during reset, MdBusy=0 and StallCnt=0 after release. Also force StallCnt to all-ones -> stays all-ones on further stalls.

Source files
------------

// File: rtl/hazard_ctl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_ctl_pkg;

  localparam int unsigned REG_W   = 5;
  localparam int unsigned MDCNT_W = 5;

  typedef enum logic {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } mdState_t;

  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  // Operand source selects for the EX stage muxes.
  localparam logic FWD_REG = 1'b0;
  localparam logic FWD_ME  = 1'b1;

endpackage

// File: rtl/hazard_fwd.sv
// ME->EX forwarding compare for both EX source operands.
module hazard_fwd
  import hazard_ctl_pkg::*;
(
  input  logic             RegWrite_ME,
  input  logic [REG_W-1:0] WriteReg_ME,
  input  logic [REG_W-1:0] Rs_EX,
  input  logic [REG_W-1:0] Rt_EX,
  output logic             FwdA,
  output logic             FwdB
);

  logic meValid;

  // $zero is never a forwarding source.
  assign meValid = RegWrite_ME && (WriteReg_ME != REG_ZERO);
  assign FwdA    = (meValid && (WriteReg_ME == Rs_EX)) ? FWD_ME : FWD_REG;
  assign FwdB    = (meValid && (WriteReg_ME == Rt_EX)) ? FWD_ME : FWD_REG;

endmodule

// File: rtl/hazard_ctl.sv
// Hazard controller for the 4-stage core: stalls, flushes, forwarding,
// mult/div busy sequencing and a saturating stall-cycle counter.
module hazard_ctl
  import hazard_ctl_pkg::*;
#(
  parameter int unsigned MD_LATENCY = 8,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] Rs_ID,
  input  logic [REG_W-1:0] Rt_ID,
  input  logic             UsesHiLo_ID,
  input  logic [REG_W-1:0] Rs_EX,
  input  logic [REG_W-1:0] Rt_EX,
  input  logic [REG_W-1:0] WriteReg_EX,
  input  logic             RegWrite_EX,
  input  logic             MemToReg_EX,
  input  logic             MdStart_EX,
  input  logic [REG_W-1:0] WriteReg_ME,
  input  logic             RegWrite_ME,
  input  logic             Jump_ID,
  input  logic             BranchTaken_EX,
  output logic             FwdA_EX,
  output logic             FwdB_EX,
  output logic             AnyStall,
  output logic             Flush_ID,
  output logic             Flush_EX,
  output logic             MdBusy,
  output logic [CNT_W-1:0] StallCnt
);

  mdState_t           state, stateNext;
  logic [MDCNT_W-1:0] mdCnt, mdCntNext;
  logic [CNT_W-1:0]   stallCnt;
  logic               mdBusyRaw;
  logic               ldUse, mdStall, stallReq;
  logic               fwdA, fwdB;

  hazard_fwd u_fwd (
    .RegWrite_ME (RegWrite_ME),
    .WriteReg_ME (WriteReg_ME),
    .Rs_EX       (Rs_EX),
    .Rt_EX       (Rt_EX),
    .FwdA        (fwdA),
    .FwdB        (fwdB)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= RUN;
      mdCnt    <= '0;
      stallCnt <= '0;
    end else begin
      state <= stateNext;
      mdCnt <= mdCntNext;
      if (AnyStall && (stallCnt != '1)) begin
        stallCnt <= stallCnt + CNT_W'(1);
      end
    end
  end

  // Busy window is MD_LATENCY cycles: load N-1, leave after the zero cycle.
  always_comb begin
    stateNext = state;
    mdCntNext = mdCnt;
    mdBusyRaw = 1'b0;
    case (state)
      RUN: begin
        if (MdStart_EX) begin
          stateNext = MD_WAIT;
          mdCntNext = MDCNT_W'(MD_LATENCY - 1);
        end
      end
      MD_WAIT: begin
        mdBusyRaw = 1'b1;
        if (mdCnt == '0) begin
          stateNext = RUN;
        end else begin
          mdCntNext = mdCnt - MDCNT_W'(1);
        end
      end
    endcase
  end

  assign ldUse    = RegWrite_EX && MemToReg_EX && (WriteReg_EX != REG_ZERO) &&
                    ((WriteReg_EX == Rs_ID) || (WriteReg_EX == Rt_ID));
  assign mdStall  = mdBusyRaw && UsesHiLo_ID;
  assign stallReq = ldUse || mdStall;

  // A taken branch wins over any stall so the redirect PC can load.
  assign AnyStall = !reset && !BranchTaken_EX && stallReq;
  assign Flush_EX = !reset && (BranchTaken_EX || stallReq);
  assign Flush_ID = !reset && (BranchTaken_EX || (Jump_ID && !stallReq));
  assign FwdA_EX  = !reset && fwdA;
  assign FwdB_EX  = !reset && fwdB;
  assign MdBusy   = !reset && mdBusyRaw;
  assign StallCnt = reset ? '0 : stallCnt;

endmodule

// File: tb/tb_hazard_ctl.sv
// Directed bench for hazard_ctl with a cycle-level reference model.
module tb_hazard_ctl;

  localparam int unsigned LAT   = 8;
  localparam int unsigned CW    = 4;
  localparam int unsigned CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [4:0]    Rs_ID, Rt_ID, Rs_EX, Rt_EX, WriteReg_EX, WriteReg_ME;
  logic          UsesHiLo_ID, RegWrite_EX, MemToReg_EX, MdStart_EX;
  logic          RegWrite_ME, Jump_ID, BranchTaken_EX;
  logic          FwdA_EX, FwdB_EX, AnyStall, Flush_ID, Flush_EX, MdBusy;
  logic [CW-1:0] StallCnt;

  int passCnt  = 0;
  int checkCnt = 0;
  int mdRemain = 0;
  int stallM   = 0;
  bit running  = 1'b1;

  hazard_ctl #(.MD_LATENCY(LAT), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .Rs_ID(Rs_ID), .Rt_ID(Rt_ID), .UsesHiLo_ID(UsesHiLo_ID),
    .Rs_EX(Rs_EX), .Rt_EX(Rt_EX), .WriteReg_EX(WriteReg_EX),
    .RegWrite_EX(RegWrite_EX), .MemToReg_EX(MemToReg_EX), .MdStart_EX(MdStart_EX),
    .WriteReg_ME(WriteReg_ME), .RegWrite_ME(RegWrite_ME),
    .Jump_ID(Jump_ID), .BranchTaken_EX(BranchTaken_EX),
    .FwdA_EX(FwdA_EX), .FwdB_EX(FwdB_EX), .AnyStall(AnyStall),
    .Flush_ID(Flush_ID), .Flush_EX(Flush_EX), .MdBusy(MdBusy), .StallCnt(StallCnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checkCnt++;
    if (act == exp) passCnt++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Spec-level reference: a remaining-busy-cycles count and a stall tally.
  function automatic bit mLdUse();
    return RegWrite_EX && MemToReg_EX && WriteReg_EX != 0 &&
           (WriteReg_EX == Rs_ID || WriteReg_EX == Rt_ID);
  endfunction
  function automatic bit mStallReq();
    return mLdUse() || (mdRemain > 0 && UsesHiLo_ID);
  endfunction
  function automatic bit mStall();
    return !reset && !BranchTaken_EX && mStallReq();
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      mdRemain = 0;
      stallM   = 0;
    end else begin
      if (mStall() && stallM < int'(CMAX)) stallM++;
      if (mdRemain > 0) mdRemain--;
      else if (MdStart_EX) mdRemain = LAT;
    end
  end

  always @(negedge clk) begin
    if (running) begin
      check("cmp_fwdA", int'(FwdA_EX),
            int'(!reset && RegWrite_ME && WriteReg_ME != 0 && WriteReg_ME == Rs_EX));
      check("cmp_fwdB", int'(FwdB_EX),
            int'(!reset && RegWrite_ME && WriteReg_ME != 0 && WriteReg_ME == Rt_EX));
      check("cmp_stall", int'(AnyStall), int'(mStall()));
      check("cmp_flushEx", int'(Flush_EX), int'(!reset && (BranchTaken_EX || mStallReq())));
      check("cmp_flushId", int'(Flush_ID),
            int'(!reset && (BranchTaken_EX || (Jump_ID && !mStallReq()))));
      check("cmp_busy", int'(MdBusy), int'(!reset && mdRemain > 0));
      check("cmp_cnt", int'(StallCnt), reset ? 0 : stallM);
    end
  end

  task automatic clearIn();
    Rs_ID = 0; Rt_ID = 0; Rs_EX = 0; Rt_EX = 0; WriteReg_EX = 0; WriteReg_ME = 0;
    UsesHiLo_ID = 0; RegWrite_EX = 0; MemToReg_EX = 0; MdStart_EX = 0;
    RegWrite_ME = 0; Jump_ID = 0; BranchTaken_EX = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic setLoad(input logic [4:0] dst, input logic [4:0] rs, input logic [4:0] rt);
    RegWrite_EX = 1; MemToReg_EX = 1; WriteReg_EX = dst; Rs_ID = rs; Rt_ID = rt;
  endtask

  initial begin
    reset = 1;
    clearIn();
    // reset gates everything even with hazards present
    RegWrite_ME = 1; WriteReg_ME = 5; Rs_EX = 5; Rt_EX = 5;
    setLoad(8, 8, 0); BranchTaken_EX = 1;
    tick(); tick(); settle();
    check("rst_fwdA", int'(FwdA_EX), 0);
    check("rst_stall", int'(AnyStall), 0);
    check("rst_flushId", int'(Flush_ID), 0);
    check("rst_cnt", int'(StallCnt), 0);

    tick(); reset = 0; clearIn();
    RegWrite_ME = 1; WriteReg_ME = 5; Rs_EX = 5; Rt_EX = 5; settle();
    check("fwd_both_A", int'(FwdA_EX), 1);
    check("fwd_both_B", int'(FwdB_EX), 1);
    tick(); WriteReg_ME = 0; Rs_EX = 0; Rt_EX = 0; settle();
    check("fwd_zero_A", int'(FwdA_EX), 0);
    check("fwd_zero_B", int'(FwdB_EX), 0);
    tick(); WriteReg_ME = 5; Rs_EX = 5; Rt_EX = 6; settle();
    check("fwd_onlyA_B", int'(FwdB_EX), 0);

    // load-use: one stall then bubble clears it
    tick(); clearIn(); setLoad(8, 9, 8); settle();
    check("ld_stall", int'(AnyStall), 1);
    check("ld_flushEx", int'(Flush_EX), 1);
    check("ld_flushId", int'(Flush_ID), 0);
    tick(); clearIn(); Rt_ID = 8; settle();
    check("ld_release", int'(AnyStall), 0);
    check("ld_cnt", int'(StallCnt), 1);
    tick(); setLoad(0, 0, 0); settle();
    check("ld_r0", int'(AnyStall), 0);

    // jump held off by a stall, taken the next cycle
    tick(); clearIn(); setLoad(3, 3, 0); Jump_ID = 1; settle();
    check("jmp_stall_flushId", int'(Flush_ID), 0);
    tick(); clearIn(); Jump_ID = 1; settle();
    check("jmp_flushId", int'(Flush_ID), 1);
    check("jmp_flushEx", int'(Flush_EX), 0);
    check("jmp_cnt", int'(StallCnt), 2);

    // branch beats load-use
    tick(); clearIn(); setLoad(4, 4, 4); BranchTaken_EX = 1; settle();
    check("br_flushId", int'(Flush_ID), 1);
    check("br_flushEx", int'(Flush_EX), 1);
    check("br_stall", int'(AnyStall), 0);
    tick(); clearIn(); settle();
    check("br_cnt", int'(StallCnt), 2);

    // mult/div issue then mflo waiting in ID
    MdStart_EX = 1; settle();
    check("md_issue_busy", int'(MdBusy), 0);
    for (int i = 0; i < int'(LAT); i++) begin
      tick(); clearIn(); UsesHiLo_ID = 1;
      if (i == 3) setLoad(7, 7, 0);
      settle();
      check("md_busy", int'(MdBusy), 1);
      check("md_stall", int'(AnyStall), 1);
    end
    tick(); clearIn(); UsesHiLo_ID = 1; settle();
    check("md_done_busy", int'(MdBusy), 0);
    check("md_done_stall", int'(AnyStall), 0);
    check("md_cnt", int'(StallCnt), 2 + int'(LAT));

    // reset three cycles into the busy window
    tick(); clearIn(); MdStart_EX = 1;
    tick(); clearIn();
    tick(); tick(); settle();
    check("mdr_busy_pre", int'(MdBusy), 1);
    tick(); reset = 1; UsesHiLo_ID = 1; setLoad(2, 2, 2); Jump_ID = 1; settle();
    check("mdr_rst_busy", int'(MdBusy), 0);
    check("mdr_rst_stall", int'(AnyStall), 0);
    check("mdr_rst_flushEx", int'(Flush_EX), 0);
    tick(); settle();
    check("mdr_rst_cnt", int'(StallCnt), 0);
    tick(); reset = 0; clearIn(); UsesHiLo_ID = 1; settle();
    check("mdr_after_busy", int'(MdBusy), 0);
    check("mdr_after_cnt", int'(StallCnt), 0);

    // saturation of the stall counter
    tick(); clearIn(); setLoad(6, 6, 0);
    for (int i = 0; i < 20; i++) tick();
    settle();
    check("sat_cnt", int'(StallCnt), int'(CMAX));
    tick(); tick(); settle();
    check("sat_hold", int'(StallCnt), int'(CMAX));

    tick(); clearIn(); tick();
    running = 1'b0;
    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
